// File: rtl/deserializador_sync.sv
// deserializador_sync: serial-to-parallel converter with comma alignment and lock.
// Optional DESER_REALIGN_EN: drop lock after LOSS_THR misaligned commas.
module deserializador_sync #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] COMMA = WIDTH'(8'hBC),
  parameter int N_COMMA = 4,
  parameter int LOSS_THR = 3
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             word_tick,
  output logic             lock
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] BMAX = CW'(WIDTH - 1);
  localparam logic [3:0] NC = 4'(N_COMMA);

  if (WIDTH < 4 || WIDTH > 16 || N_COMMA < 1 || N_COMMA > 15 ||
      LOSS_THR < 1) begin : g_param_chk
    $error("deserializador_sync: parameter out of range");
  end

  typedef enum logic [1:0] {S_SEARCH, S_ALIGN, S_LOCKED} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       comma_cnt_q, comma_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             tick_q, tick_d;
  logic             lock_q, lock_d;
`ifdef DESER_REALIGN_EN
  logic [7:0]       miss_cnt_q, miss_cnt_d;
`endif

  logic [WIDTH-1:0] win;
  logic             is_comma;
  logic             boundary;

  always_comb begin
    win         = {sr_q, data_in};
    is_comma    = (win == COMMA);
    boundary    = (bit_cnt_q == BMAX);
    state_d     = state_q;
    sr_d        = win[WIDTH-2:0];
    bit_cnt_d   = boundary ? '0 : bit_cnt_q + CW'(1);
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    tick_d      = 1'b0;
    lock_d      = lock_q;
`ifdef DESER_REALIGN_EN
    miss_cnt_d  = miss_cnt_q;
`endif
    unique case (state_q)
      S_SEARCH: begin
        bit_cnt_d = '0;
        if (is_comma) begin
          comma_cnt_d = 4'd1;
          if (N_COMMA == 1) begin
            state_d = S_LOCKED;
            lock_d  = 1'b1;
            tick_d  = 1'b1;
          end else begin
            state_d = S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        if (boundary) begin
          if (is_comma) begin
            if (comma_cnt_q + 4'd1 >= NC) begin
              comma_cnt_d = NC;
              state_d     = S_LOCKED;
              lock_d      = 1'b1;
              tick_d      = 1'b1;
            end else begin
              comma_cnt_d = comma_cnt_q + 4'd1;
            end
          end else begin
            state_d     = S_SEARCH;
            comma_cnt_d = '0;
          end
        end
      end
      S_LOCKED: begin
        if (boundary) begin
          tick_d = 1'b1;
          if (is_comma) begin
            valid_d = 1'b0;
          end else begin
            data_d  = win;
            valid_d = 1'b1;
          end
        end
`ifdef DESER_REALIGN_EN
        if (is_comma && boundary) begin
          miss_cnt_d = '0;
        end else if (is_comma) begin
          // a comma off the word grid means we slipped
          if (miss_cnt_q + 8'd1 >= 8'(LOSS_THR)) begin
            state_d     = S_SEARCH;
            lock_d      = 1'b0;
            valid_d     = 1'b0;
            miss_cnt_d  = '0;
            comma_cnt_d = '0;
            bit_cnt_d   = '0;
          end else begin
            miss_cnt_d = miss_cnt_q + 8'd1;
          end
        end
`endif
      end
      default: begin
        state_d = S_SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= S_SEARCH;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      tick_q      <= 1'b0;
      lock_q      <= 1'b0;
`ifdef DESER_REALIGN_EN
      miss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      tick_q      <= tick_d;
      lock_q      <= lock_d;
`ifdef DESER_REALIGN_EN
      miss_cnt_q  <= miss_cnt_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign word_tick = tick_q;
  assign lock      = lock_q;
endmodule
